// File: rtl/vga_timing_ctrl.sv
// vga_timing_ctrl: VGA raster timing with sync/RGB aligned to the draw stage read latency
module vga_timing_ctrl #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int DRAW_LAT = 1,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic        pix_clk,
  input  logic        pix_rst,
  input  logic [11:0] pix_data,
  output logic [11:0] pix_x,
  output logic [11:0] pix_y,
  output logic        pix_valid,
  output logic        frame_start,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);
  localparam int HL = DRAW_LAT + 1;
  localparam logic [11:0] HA     = 12'(H_ACTIVE);
  localparam logic [11:0] VA     = 12'(V_ACTIVE);
  localparam logic [11:0] HT_M1  = 12'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] VT_M1  = 12'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [11:0] HS_BEG = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [11:0] VS_BEG = 12'(V_ACTIVE + V_FP);
  localparam logic [11:0] VS_END = 12'(V_ACTIVE + V_FP + V_SYNC);
  logic [11:0]       r_h_cnt, r_v_cnt, r_rgb;
  logic [DRAW_LAT:0] r_hs_d, r_vs_d;
  logic [DRAW_LAT-1:0] r_vld_d;
  logic              w_active, w_hs, w_vs;
  // Coordinate bus is combinational from the counters and held at zero in reset
  always_comb begin
    w_active    = !pix_rst && r_h_cnt < HA && r_v_cnt < VA;
    pix_valid   = w_active;
    pix_x       = w_active ? r_h_cnt : 12'h000;
    pix_y       = w_active ? r_v_cnt : 12'h000;
    frame_start = !pix_rst && r_h_cnt == 12'h000 && r_v_cnt == 12'h000;
    w_hs        = (r_h_cnt >= HS_BEG && r_h_cnt < HS_END) ? SYNC_POL : ~SYNC_POL;
    w_vs        = (r_v_cnt >= VS_BEG && r_v_cnt < VS_END) ? SYNC_POL : ~SYNC_POL;
    hsync       = r_hs_d[DRAW_LAT];
    vsync       = r_vs_d[DRAW_LAT];
    {vga_r, vga_g, vga_b} = r_rgb;
  end
  // Raster counters: column wraps every line, row advances on the last column
  always_ff @(posedge pix_clk or posedge pix_rst)
    if (pix_rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else begin
      r_h_cnt <= (r_h_cnt == HT_M1) ? 12'h000 : r_h_cnt + 12'd1;
      if (r_h_cnt == HT_M1) r_v_cnt <= (r_v_cnt == VT_M1) ? 12'h000 : r_v_cnt + 12'd1;
    end
  // Sync and valid delay lines match the draw latency; RGB register blanks outside the active area
  always_ff @(posedge pix_clk or posedge pix_rst)
    if (pix_rst) begin
      r_hs_d  <= {HL{~SYNC_POL}};
      r_vs_d  <= {HL{~SYNC_POL}};
      r_vld_d <= '0;
      r_rgb   <= '0;
    end else begin
      r_hs_d  <= HL'({r_hs_d, w_hs});
      r_vs_d  <= HL'({r_vs_d, w_vs});
      r_vld_d <= DRAW_LAT'({r_vld_d, w_active});
      r_rgb   <= r_vld_d[DRAW_LAT-1] ? pix_data : 12'h000;
    end
endmodule

// File: tb/tb_vga_timing_ctrl.sv
// tb_vga_timing_ctrl: scoreboard bench for two raster instances (draw latency 1 and 3)
module tb_vga_timing_ctrl;
  typedef struct {int due; logic [13:0] v;} exp_t;
  logic clk = 1'b0;
  logic [1:0] rst = 2'b11;
  logic [1:0] done = 2'b00;
  int cyc = 0;
  int n_chk = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask
  for (genvar g = 0; g < 2; g++) begin : u
    localparam int LAT = (g == 0) ? 1 : 3;
    localparam int VA  = (g == 0) ? 4 : 3;
    localparam int VF  = (g == 0) ? 1 : 2;
    localparam int VS  = 2;
    localparam int VB  = (g == 0) ? 1 : 2;
    localparam int VT  = VA + VF + VS + VB;
    logic [11:0] pd, px, py;
    logic [11:0] rom [LAT];
    logic        pv, fs, hs, vs;
    logic [3:0]  vr, vg, vb;
    exp_t        q[$];
    int          bh = 0;
    int          bv = 0;
    vga_timing_ctrl #(.V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .DRAW_LAT(LAT)) dut (
      .pix_clk(clk), .pix_rst(rst[g]), .pix_data(pd), .pix_x(px), .pix_y(py),
      .pix_valid(pv), .frame_start(fs), .hsync(hs), .vsync(vs),
      .vga_r(vr), .vga_g(vg), .vga_b(vb));
    // draw stage model: ROM of the coordinate, 12'hFFF for blanked coordinates
    always @(posedge clk) begin
      rom[0] <= pv ? {px[3:0], py[3:0], 4'h5} : 12'hFFF;
      for (int i = 1; i < LAT; i++) rom[i] <= rom[i-1];
    end
    assign pd = rom[LAT-1];
    // stimulus side: check coordinates now, queue the connector-side expectation
    initial forever begin
      logic ev;
      @(negedge clk);
      if (rst[g]) begin
        bh = 0;
        bv = 0;
        q.delete();
      end else begin
        ev = bh < 640 && bv < VA;
        chk("coord", {fs, pv, px, py},
            {6'b0, bh == 0 && bv == 0, ev, ev ? 12'(bh) : 12'h0, ev ? 12'(bv) : 12'h0});
        q.push_back('{cyc + LAT + 1, {ev ? {4'(bh), 4'(bv), 4'h5} : 12'h000,
                     !(bh >= 656 && bh < 752), !(bv >= VA + VF && bv < VA + VF + VS)}});
        bh++;
        if (bh == 800) begin
          bh = 0;
          bv = (bv == VT - 1) ? 0 : bv + 1;
        end
      end
    end
    // monitor: compare connector outputs against the queued expectation that is due
    initial forever begin
      exp_t e;
      @(negedge clk);
      if (!rst[g])
        while (q.size() > 0 && q[0].due == cyc) begin
          e = q.pop_front();
          chk("rgb_sync", {vr, vg, vb, hs, vs}, e.v);
        end
    end
    // line and frame timing measured relative to the first frame_start
    initial begin
      int c0 = -1, f1 = -1, hf0 = -1, hf1 = -1, hr = -1, vf = -1, vrs = -1, nv = 0;
      logic phs = 1'b1, pvs = 1'b1;
      for (int k = 0; k < VT * 800 + 50; k++) begin
        @(negedge clk);
        if (fs) begin
          if (c0 < 0) c0 = cyc;
          else if (f1 < 0) f1 = cyc;
        end
        if (c0 >= 0 && cyc < c0 + 800 && pv) nv++;
        if (phs && !hs) begin
          if (hf0 < 0) hf0 = cyc;
          else if (hf1 < 0) hf1 = cyc;
        end
        if (!phs && hs && hf0 >= 0 && hr < 0) hr = cyc;
        if (pvs && !vs && vf < 0) vf = cyc;
        if (!pvs && vs && vf >= 0 && vrs < 0) vrs = cyc;
        phs = hs;
        pvs = vs;
      end
      chk("hsync_fall", hf0 - c0, 656 + LAT + 1);
      chk("hsync_low", hr - hf0, 96);
      chk("hsync_period", hf1 - hf0, 800);
      chk("valid_per_line", nv, 640);
      chk("vsync_fall", vf - c0, (VA + VF) * 800 + LAT + 1);
      chk("vsync_low", vrs - vf, 1600);
      chk("frame_period", f1 - c0, VT * 800);
      done[g] = 1'b1;
    end
  end
  initial begin
    bit found;
    repeat (5) @(posedge clk);
    #2;
    chk("rst0_out", {u[0].hs, u[0].vs, u[0].vr, u[0].vg, u[0].vb, u[0].pv, u[0].fs}, {2'b11, 12'h0, 2'b00});
    chk("rst1_out", {u[1].hs, u[1].vs, u[1].vr, u[1].vg, u[1].vb, u[1].pv, u[1].fs}, {2'b11, 12'h0, 2'b00});
    rst = 2'b00;
    #1;
    chk("rel0_coord", {u[0].fs, u[0].pv, u[0].px, u[0].py}, {2'b11, 24'h0});
    chk("rel1_coord", {u[1].fs, u[1].pv, u[1].px, u[1].py}, {2'b11, 24'h0});
    wait (&done);
    found = 0;
    for (int k = 0; k < 7000 && !found; k++) begin
      @(posedge clk);
      #1;
      found = u[0].px == 12'd300 && u[0].py == 12'd1;
    end
    chk("locate0", found, 1'b1);
    chk("pre_rst0_rgb", {u[0].vr, u[0].vg, u[0].vb}, 12'hA15);
    #3 rst[0] = 1'b1;
    #1;
    chk("mid_rst0_out", {u[0].hs, u[0].vs, u[0].vr, u[0].vg, u[0].vb, u[0].pv, u[0].fs, u[0].px, u[0].py},
        {2'b11, 12'h0, 2'b00, 24'h0});
    repeat (3) @(posedge clk);
    #2 rst[0] = 1'b0;
    #1;
    chk("mid_rel0_coord", {u[0].fs, u[0].pv, u[0].px, u[0].py}, {2'b11, 24'h0});
    found = 0;
    for (int k = 0; k < 8000 && !found; k++) begin
      @(posedge clk);
      #1;
      found = !u[1].hs && !u[1].vs;
    end
    chk("locate1", found, 1'b1);
    repeat (40) @(posedge clk);
    #1;
    chk("pre_rst1_sync", {u[1].hs, u[1].vs}, 2'b00);
    #3 rst[1] = 1'b1;
    #1;
    chk("mid_rst1_out", {u[1].hs, u[1].vs, u[1].vr, u[1].vg, u[1].vb, u[1].pv, u[1].fs}, {2'b11, 12'h0, 2'b00});
    repeat (3) @(posedge clk);
    #2 rst[1] = 1'b0;
    #1;
    chk("mid_rel1_coord", {u[1].fs, u[1].pv, u[1].px, u[1].py}, {2'b11, 24'h0});
    repeat (900) @(posedge clk);
    #2;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end
endmodule
